// File: rtl/mu_fifo_pkg.sv
// Shared types for the mu_fifo family: skid-stage state encoding.
package mu_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FULL = 2'd2
   } mu_wreg_state_t;

endpackage : mu_fifo_pkg

// File: rtl/mu_fifo_sync.sv
// Storage FIFO: circular buffer with a word counter. Read side is
// first-word fall-through; rd_valid is high whenever a word is held.
module mu_fifo_sync #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          rd_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   assign wr_ready = (count != CW'(DEPTH));
   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_valid && rd_ready;

   // Data array carries no reset; contents are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap explicitly so non-power-of-two depths also work.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

endmodule : mu_fifo_sync

// File: rtl/mu_fifo_sync_wreg.sv
// FIFO with a fully registered write side: a two-entry skid stage
// (main + skid) feeds the storage FIFO so wr_ready comes from a flop.
//
// state | meaning
// IDLE  | main and skid empty
// BUSY  | main holds a word, skid empty
// FULL  | main and skid both hold words; writes refused
module mu_fifo_sync_wreg
   import mu_fifo_pkg::*;
#(
   parameter  int DW       = 64,
   parameter  int DEPTH    = 4,
   parameter  int AF_LEVEL = DEPTH,
   localparam int LW       = $clog2(DEPTH + 3)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [LW-1:0] level,
   output logic          almost_full
);

   mu_wreg_state_t state;
   mu_wreg_state_t state_next;
   logic [DW-1:0]  main_data;
   logic [DW-1:0]  skid_data;
   logic           main_valid;
   logic           fifo_wr_ready;
   logic           wr_xfer;
   logic           rd_xfer;
   logic           push;
   logic           load_main_wr;
   logic           load_main_skid;
   logic           load_skid;
   logic [LW-1:0]  level_next;

   assign main_valid = (state != IDLE);
   assign wr_xfer    = wr_valid && wr_ready;
   assign rd_xfer    = rd_valid && rd_ready;
   assign push       = main_valid && fifo_wr_ready;

   mu_fifo_sync #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (main_data),
      .wr_valid (main_valid),
      .wr_ready (fifo_wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready)
   );

   // Skid FSM next state and register load selects.
   always_comb begin
      state_next     = state;
      load_main_wr   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         IDLE: begin
            if (wr_xfer) begin
               load_main_wr = 1'b1;
               state_next   = BUSY;
            end
         end
         BUSY: begin
            if (wr_xfer && push) begin
               load_main_wr = 1'b1;
            end else if (wr_xfer) begin
               load_skid  = 1'b1;
               state_next = FULL;
            end else if (push) begin
               state_next = IDLE;
            end
         end
         FULL: begin
            // Older skid word moves up before any new word can be taken.
            if (push) begin
               load_main_skid = 1'b1;
               state_next     = BUSY;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Fill level tracks writes in and reads out across skid and storage.
   always_comb begin
      level_next = level;
      if (wr_xfer && !rd_xfer)      level_next = level + LW'(1);
      else if (rd_xfer && !wr_xfer) level_next = level - LW'(1);
   end

   // State, registered ready, level and almost-full flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_ready    <= 1'b0;
         level       <= '0;
         almost_full <= 1'b0;
      end else begin
         state       <= state_next;
         wr_ready    <= (state_next != FULL);
         level       <= level_next;
         almost_full <= (level_next >= LW'(AF_LEVEL));
      end
   end

   // Skid data registers; no reset since validity lives in the state.
   always_ff @(posedge clk) begin
      if (load_main_wr)        main_data <= wr_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= wr_data;
   end

   // Level must stay inside 0..DEPTH+2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(wr_xfer && !rd_xfer && level == LW'(DEPTH + 2)));
         assert (!(rd_xfer && !wr_xfer && level == '0));
      end
   end

endmodule : mu_fifo_sync_wreg

// File: tb/tb_mu_fifo_sync_wreg.sv
// Bench for mu_fifo_sync_wreg: directed scenarios plus random stress,
// checked against a queue-based model of words held.
module tb_mu_fifo_sync_wreg;

   localparam int DW       = 64;
   localparam int DEPTH    = 4;
   localparam int AF_LEVEL = DEPTH;
   localparam int LW       = $clog2(DEPTH + 3);

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [LW-1:0] level;
   logic          almost_full;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_wr  = 0;
   int            n_rd  = 0;
   bit            last_wx;
   logic [63:0]   q[$];
   logic [63:0]   rd_log[$];

   always #5 clk = ~clk;

   mu_fifo_sync_wreg #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_data     (wr_data),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .level       (level),
      .almost_full (almost_full)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample transfers before the edge, update the model, check after.
   task automatic cycle();
      bit          wx;
      bit          rx;
      bit          r;
      logic [63:0] wd;
      logic [63:0] rdv;
      wx  = (wr_valid === 1'b1) && (wr_ready === 1'b1);
      rx  = (rd_valid === 1'b1) && (rd_ready === 1'b1);
      r   = (rst === 1'b1);
      wd  = wr_data;
      rdv = rd_data;
      if (rx && !r) begin
         if (q.size() == 0) check("read_from_empty", 64'(rd_valid), 64'd0);
         else               check("rd_data_order", rdv, q[0]);
      end
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
      end else begin
         if (rx) begin
            if (q.size() > 0) void'(q.pop_front());
            rd_log.push_back(rdv);
            n_rd++;
         end
         if (wx) begin
            q.push_back(wd);
            n_wr++;
         end
      end
      last_wx = wx && !r;
      check("level", 64'(level), 64'(q.size()));
      check("almost_full", 64'(almost_full), 64'(q.size() >= AF_LEVEL));
      if (r) begin
         check("rd_valid_in_reset", 64'(rd_valid), 64'd0);
         check("wr_ready_in_reset", 64'(wr_ready), 64'd0);
      end else begin
         if (rd_valid === 1'b1) check("rd_valid_nonempty", 64'(q.size() > 0), 64'd1);
         if (wr_ready !== 1'b1) check("wr_ready_low_near_full", 64'(q.size() >= DEPTH + 1), 64'd1);
      end
   endtask

   task automatic drain();
      rd_ready = 1'b1;
      wr_valid = 1'b0;
      for (int i = 0; i < 30 && q.size() > 0; i++) cycle();
      check("drain_done", 64'(q.size()), 64'd0);
      rd_ready = 1'b0;
   endtask

   initial begin
      int rise;

      // Reset with a write request held: nothing may be stored.
      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 64'hDEAD;
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      rst      = 1'b0;
      wr_valid = 1'b0;
      cycle();
      check("wr_ready_after_release", 64'(wr_ready), 64'd1);
      check("rd_valid_after_release", 64'(rd_valid), 64'd0);
      check("level_after_release", 64'(level), 64'd0);

      // Single word: two cycles accept-to-valid.
      wr_data  = 64'hA5;
      wr_valid = 1'b1;
      cycle();
      wr_valid = 1'b0;
      check("single_not_yet_valid", 64'(rd_valid), 64'd0);
      cycle();
      check("single_valid", 64'(rd_valid), 64'd1);
      check("single_data", rd_data, 64'hA5);
      check("single_level", 64'(level), 64'd1);
      rd_ready = 1'b1;
      cycle();
      rd_ready = 1'b0;
      check("single_level_after_read", 64'(level), 64'd0);

      // Fill with consumer stalled: offer 1..8, capacity is DEPTH+2.
      n_wr = 0;
      for (int v = 1; v <= 8; v++) begin
         wr_data  = 64'(v);
         wr_valid = 1'b1;
         cycle();
      end
      wr_valid = 1'b0;
      cycle();
      check("fill_accepted", 64'(n_wr), 64'(DEPTH + 2));
      check("fill_wr_ready", 64'(wr_ready), 64'd0);
      check("fill_level", 64'(level), 64'(DEPTH + 2));
      check("fill_almost_full", 64'(almost_full), 64'd1);

      // Drain after fill: strict order, ready comes back quickly.
      rd_log.delete();
      rd_ready = 1'b1;
      rise     = -1;
      for (int i = 1; i <= 20 && q.size() > 0; i++) begin
         cycle();
         if (rise < 0 && wr_ready === 1'b1) rise = i;
      end
      rd_ready = 1'b0;
      check("drain_ready_rise", 64'(rise >= 1 && rise <= 2), 64'd1);
      check("drain_count", 64'(rd_log.size()), 64'(DEPTH + 2));
      for (int i = 0; i < rd_log.size() && i < DEPTH + 2; i++)
         check("drain_order", rd_log[i], 64'(i + 1));
      check("drain_level", 64'(level), 64'd0);

      // Streaming: one word per cycle both sides.
      n_wr     = 0;
      n_rd     = 0;
      wr_data  = 64'd1000;
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (last_wx) wr_data = wr_data + 64'd1;
      end
      check("stream_writes", 64'(n_wr), 64'd100);
      check("stream_reads", 64'(n_rd), 64'd98);
      check("stream_level", 64'(level), 64'd2);
      drain();

      // Random stress with a reset in the middle.
      for (int c = 0; c < 1000; c++) begin
         rst      = (c == 500 || c == 501);
         wr_valid = ($urandom_range(0, 3) != 0);
         rd_ready = ($urandom_range(0, 2) == 0) || (c > 700 && $urandom_range(0, 1) == 1);
         wr_data  = {$urandom(), $urandom()};
         cycle();
         if (c == 501) begin
            check("post_reset_level", 64'(level), 64'd0);
            check("post_reset_rd_valid", 64'(rd_valid), 64'd0);
         end
      end
      rst = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mu_fifo_sync_wreg
